// File: rtl/wr_port_arbiter.sv
// wr_port_arbiter: packet-granular round-robin arbiter and mux for the shared write stream.
// Define ARB_TIMEOUT_EN to build in the mid-packet stall watchdog.
module wr_port_arbiter #(
   parameter int NUM_PORTS   = 4,
   parameter int DATA_W      = 32,
   parameter int TIMEOUT_CYC = 1024
) (
   input  logic                        iClk,
   input  logic                        iRst,
   input  logic [NUM_PORTS-1:0]        iReq,
   output logic [NUM_PORTS-1:0]        oGnt,
   input  logic [NUM_PORTS-1:0]        iWrSop,
   input  logic [NUM_PORTS-1:0]        iWrEop,
   input  logic [NUM_PORTS-1:0]        iWrVld,
   input  logic [NUM_PORTS*DATA_W-1:0] iWrData,
   output logic                        oWrSop,
   output logic                        oWrEop,
   output logic                        oWrVld,
   output logic [DATA_W-1:0]           oWrData,
   output logic                        oBusy,
   output logic                        oTimeout
);
   localparam int PW = $clog2(NUM_PORTS);
   typedef enum logic [1:0] {IDLE, WAIT_SOP, XFER} state_t;
   state_t            state_q, state_d;
   logic [PW-1:0]     idx_q, idx_d, rr_q, rr_d, pick, rr_nxt;
   logic [PW:0]       cand;
   logic              found, abort;
   logic              sop_q, sop_d, eop_q, eop_d, vld_q, vld_d;
   logic [DATA_W-1:0] data_q, data_d, din;
   if (NUM_PORTS < 2 || NUM_PORTS > 16 || TIMEOUT_CYC < 2) begin : g_bad_cfg
      $error("wr_port_arbiter: unsupported parameter set");
   end
   assign din    = iWrData[idx_q*DATA_W +: DATA_W];
   assign rr_nxt = (idx_q == PW'(NUM_PORTS-1)) ? '0 : idx_q + 1'b1;
   assign oBusy  = (state_q != IDLE);
   assign oGnt   = oBusy ? (NUM_PORTS'(1) << idx_q) : '0;
   assign oWrSop = sop_q;
   assign oWrEop = eop_q;
   assign oWrVld = vld_q;
   assign oWrData = data_q;
   // First requester at or after rr_q, wrapping past the last port.
   always_comb begin
      found = 1'b0;
      pick  = rr_q;
      cand  = '0;
      for (int k = 0; k < NUM_PORTS; k++) begin
         cand = {1'b0, rr_q} + (PW+1)'(k);
         cand = (cand >= (PW+1)'(NUM_PORTS)) ? cand - (PW+1)'(NUM_PORTS) : cand;
         if (!found && iReq[cand[PW-1:0]]) begin
            found = 1'b1;
            pick  = cand[PW-1:0];
         end
      end
   end
`ifdef ARB_TIMEOUT_EN
   localparam int WW = $clog2(TIMEOUT_CYC);
   logic [WW-1:0] wd_q, wd_d;
   logic          to_q;
   // A real Eop in the expiry cycle wins over the abort.
   assign abort    = oBusy && (wd_q == WW'(TIMEOUT_CYC-1)) && !(state_q == XFER && iWrEop[idx_q]);
   assign wd_d     = (state_q == IDLE || state_d == IDLE) ? '0 : wd_q + 1'b1;
   assign oTimeout = to_q;
   always_ff @(posedge iClk) begin
      if (iRst) begin
         wd_q <= '0;
         to_q <= 1'b0;
      end else begin
         wd_q <= wd_d;
         to_q <= abort;
      end
   end
`else
   assign abort    = 1'b0;
   assign oTimeout = 1'b0;
`endif
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      rr_d    = rr_q;
      sop_d   = 1'b0;
      vld_d   = 1'b0;
      eop_d   = 1'b0;
      data_d  = '0;
      case (state_q)
         IDLE:
            if (found) begin
               state_d = WAIT_SOP;
               idx_d   = pick;
            end
         WAIT_SOP:
            if (iWrSop[idx_q]) begin
               sop_d   = 1'b1;
               state_d = XFER;
            end else if (!iReq[idx_q]) begin
               state_d = IDLE;
            end
         XFER:
            if (iWrEop[idx_q]) begin
               eop_d   = 1'b1;
               state_d = IDLE;
               rr_d    = rr_nxt;
            end else if (iWrVld[idx_q]) begin
               vld_d  = 1'b1;
               data_d = din;
            end
         default: state_d = IDLE;
      endcase
      if (abort) begin
         state_d = IDLE;
         rr_d    = rr_nxt;
         sop_d   = 1'b0;
         vld_d   = 1'b0;
         data_d  = '0;
         eop_d   = (state_q == XFER);
      end
   end
   always_ff @(posedge iClk) begin
      if (iRst) begin
         state_q <= IDLE;
         idx_q   <= '0;
         rr_q    <= '0;
         sop_q   <= 1'b0;
         eop_q   <= 1'b0;
         vld_q   <= 1'b0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         rr_q    <= rr_d;
         sop_q   <= sop_d;
         eop_q   <= eop_d;
         vld_q   <= vld_d;
         data_q  <= data_d;
      end
   end
endmodule

// File: tb/tb_wr_port_arbiter.sv
// tb_wr_port_arbiter: table, directed and random checks of wr_port_arbiter against a packet-level model.
module tb_wr_port_arbiter;
   localparam int N = 4;
   localparam int W = 32;
`ifdef ARB_TIMEOUT_EN
   localparam int TO = 32;
   localparam bit TIMED = 1'b1;
`else
   localparam int TO = 1024;
   localparam bit TIMED = 1'b0;
`endif
   typedef struct {
      logic [N-1:0] req, sop, vld, eop;
      logic [W-1:0] d;
      logic [40:0]  exp;
   } vec_t;
   logic iClk = 1'b0, iRst = 1'b1;
   logic [N-1:0] req = '0, sop = '0, vld = '0, eop = '0;
   logic [N*W-1:0] data = '0;
   logic [N-1:0] oGnt;
   logic oWrSop, oWrEop, oWrVld, oBusy, oTimeout;
   logic [W-1:0] oWrData;
   int errs = 0, checks = 0, cyc = 0;
   int m_own = -1, m_rr = 0, m_cnt = 0;
   bit m_started = 1'b0;
   logic [40:0] exp_o;
   vec_t tbl[$];
   always #5 iClk = ~iClk;
   wr_port_arbiter #(.NUM_PORTS(N), .DATA_W(W), .TIMEOUT_CYC(TO)) dut (
      .iClk(iClk), .iRst(iRst), .iReq(req), .oGnt(oGnt),
      .iWrSop(sop), .iWrEop(eop), .iWrVld(vld), .iWrData(data),
      .oWrSop(oWrSop), .oWrEop(oWrEop), .oWrVld(oWrVld), .oWrData(oWrData),
      .oBusy(oBusy), .oTimeout(oTimeout));
   function automatic logic [40:0] pk(input logic [N-1:0] g, input logic b, s, v, e, t, input logic [W-1:0] d);
      return {g, b, s, v, e, t, d};
   endfunction
   function automatic logic [40:0] act();
      return pk(oGnt, oBusy, oWrSop, oWrVld, oWrEop, oTimeout, oWrData);
   endfunction
   task automatic chk(input string nm, input logic [40:0] a, input logic [40:0] e);
      checks++;
      if (a !== e) begin
         errs++;
         $display("FAIL %s cyc=%0d got=%h expected=%h", nm, cyc, a, e);
      end
   endtask
   // Packet-level view: who owns the stream, whether its Sop was seen, whose turn is next.
   task automatic model();
      logic s, v, e, t;
      logic [W-1:0] d;
      bit done;
      s = 0; v = 0; e = 0; t = 0; d = '0; done = 0;
      if (iRst) begin
         m_own = -1;
         m_rr  = 0;
      end else if (m_own < 0) begin
         for (int k = 0; k < N; k++)
            if (m_own < 0 && req[(m_rr + k) % N]) m_own = (m_rr + k) % N;
         m_started = 0;
         m_cnt = 0;
      end else begin
         if (m_started && eop[m_own]) begin
            e = 1; done = 1;
         end else if (TIMED && m_cnt == TO - 1) begin
            e = m_started; t = 1; done = 1;
         end else if (!m_started && sop[m_own]) begin
            s = 1; m_started = 1;
         end else if (!m_started && !req[m_own]) begin
            m_own = -1;
         end else if (m_started && vld[m_own]) begin
            v = 1; d = data[m_own*W +: W];
         end
         if (done) begin
            m_rr  = (m_own + 1) % N;
            m_own = -1;
         end else if (m_own >= 0) begin
            m_cnt++;
         end
      end
      exp_o = pk((m_own < 0) ? '0 : N'(1) << m_own, m_own >= 0, s, v, e, t, d);
   endtask
   task automatic step();
      model();
      @(posedge iClk);
      #1;
      cyc++;
      chk("model", act(), exp_o);
   endtask
   task automatic clr();
      sop = '0; vld = '0; eop = '0;
   endtask
   task automatic noise(input int q, input int c);
      if (q >= 0) begin
         if (c % 3 == 0) sop[q] = 1'b1;
         else if (c % 3 == 1) vld[q] = 1'b1;
         else eop[q] = 1'b1;
         data[q*W +: W] = $urandom;
      end
   endtask
   task automatic pkt(input int p, input int n, input int q);
      clr(); sop[p] = 1'b1; noise(q, 0); step();
      clr(); vld[p] = 1'b1; data[p*W +: W] = 32'h0000_3F00; noise(q, 1); step();
      for (int i = 0; i < n; i++) begin
         clr(); vld[p] = 1'b1; data[p*W +: W] = $urandom; noise(q, i + 2); step();
      end
      clr(); eop[p] = 1'b1; req[p] = 1'b0; noise(q, 2); step();
      clr();
   endtask
   task automatic do_reset();
      iRst = 1'b1; clr(); req = '0; step();
      chk("reset", act(), '0);
      iRst = 1'b0;
   endtask
   task automatic add(input logic [N-1:0] r, s, v, e, input logic [W-1:0] d, input logic [40:0] x);
      vec_t t;
      t.req = r; t.sop = s; t.vld = v; t.eop = e; t.d = d; t.exp = x;
      tbl.push_back(t);
   endtask
   initial begin
      int n;
      do_reset();
      add(4'b0100, 0, 0, 0, 0, pk(4'b0100, 1, 0, 0, 0, 0, 0));
      add(4'b0100, 4'b0100, 0, 0, 0, pk(4'b0100, 1, 1, 0, 0, 0, 0));
      add(4'b0100, 0, 4'b0100, 0, 32'h0000_3F00, pk(4'b0100, 1, 0, 1, 0, 0, 32'h0000_3F00));
      for (int i = 0; i < 16; i++) begin
         add(4'b0100, 0, 4'b0100, 0, 32'hA500_0000 + i, pk(4'b0100, 1, 0, 1, 0, 0, 32'hA500_0000 + i));
         if (i == 7) add(4'b0100, 0, 0, 0, 0, pk(4'b0100, 1, 0, 0, 0, 0, 0));
      end
      add(4'b0000, 0, 0, 4'b0100, 0, pk(4'b0000, 0, 0, 0, 1, 0, 0));
      add(4'b0000, 0, 0, 0, 0, '0);
      for (int i = 0; i < tbl.size(); i++) begin
         req = tbl[i].req; sop = tbl[i].sop; vld = tbl[i].vld; eop = tbl[i].eop;
         data = {$urandom, $urandom, $urandom, $urandom};
         data[2*W +: W] = tbl[i].d;
         step();
         chk("tbl", act(), tbl[i].exp);
      end
      clr(); req = 4'b1001; step();
      chk("rr_after_p2", oGnt, 4'b1000);
      req = 4'b1000; sop[3] = 1'b1; step();
      clr(); vld[3] = 1'b1; step();
      clr(); iRst = 1'b1; vld[3] = 1'b1; step();
      chk("rst_mid_xfer", act(), '0);
      clr(); iRst = 1'b0; req = 4'b1100; step();
      chk("rst_rr0", oGnt, 4'b0100);
      req = '0; step();
      do_reset();
      req = 4'b1111; step();
      chk("cont_g0", oGnt, 4'b0001);
      for (int i = 0; i < N; i++) begin
         pkt(i, 16, -1);
         chk("cont_gap", oGnt, 0);
         if (i < N - 1) begin
            step();
            chk("cont_next", oGnt, N'(1) << (i + 1));
         end
      end
      do_reset();
      req = 4'b0001; step();
      req = 4'b0011;
      pkt(0, 16, 1);
      chk("iso_gap", oGnt, 0);
      step();
      chk("iso_next", oGnt, 4'b0010);
      req = '0; step();
      do_reset();
      req = 4'b1000; step();
      chk("wdr_g3", oGnt, 4'b1000);
      req = 4'b1001; step();
      req = 4'b0001; step();
      chk("wdr_withdraw", act(), '0);
      step();
      chk("wdr_next", oGnt, 4'b0001);
      req = '0; step();
`ifdef ARB_TIMEOUT_EN
      do_reset();
      req = 4'b0110; step();
      chk("wdog_g1", oGnt, 4'b0010);
      req = 4'b0100; sop[1] = 1'b1; step();
      clr(); vld[1] = 1'b1; step(); step(); step();
      clr();
      n = 4;
      while (!oTimeout && n < 40) begin
         step();
         n++;
      end
      chk("wdog_cycles", n, 32);
      chk("wdog_eop", oWrEop, 1);
      step();
      chk("wdog_next", oGnt, 4'b0100);
      eop[1] = 1'b1; step();
      chk("wdog_late_eop", oWrEop, 0);
      clr(); req = '0; step();
`endif
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         iRst = ($urandom_range(0, 299) == 0);
         for (int p = 0; p < N; p++) begin
            int r;
            r = $urandom_range(0, 9);
            req[p] = ($urandom_range(0, 3) != 0);
            sop[p] = (r == 0);
            eop[p] = (r == 1);
            vld[p] = (r >= 2 && r <= 5);
         end
         data = {$urandom, $urandom, $urandom, $urandom};
         step();
      end
      iRst = 1'b0;
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule

// File: doc/wr_port_arbiter.md
# wr_port_arbiter

Packet-granular round-robin arbiter and mux for the switch write path: shares one Sop/Vld/Data/Eop write interface (the stream that feeds CRC insertion and buffer write) among NUM_PORTS ingress requesters. Each grant covers exactly one whole packet, from Sop through Eop; a busy port never interleaves words with another port. An optional watchdog reclaims the interface from a requester that stalls mid-packet.

## Interface
- NUM_PORTS, 4: number of requesters (2..16)
- DATA_W, 32: write data width
- TIMEOUT_CYC, 1024: watchdog limit in cycles, counted from grant (used only with ARB_TIMEOUT_EN)
- iClk  in  1  clock, all logic on rising edge
- iRst  in  1  synchronous, active-high reset
- iReq  in  NUM_PORTS  per-port packet request, level, held until granted
- oGnt  out  NUM_PORTS  one-hot grant, registered
- iWrSop / iWrEop / iWrVld  in  NUM_PORTS each  per-port packet strobes, same framing as the output
- iWrData  in  NUM_PORTS*DATA_W  per-port data, port i in bits [i*DATA_W +: DATA_W]
- oWrSop / oWrEop / oWrVld  out  1 each  muxed strobes, registered
- oWrData  out  DATA_W  muxed data, registered, 0 when oWrVld=0
- oBusy  out  1  high from grant until release
- oTimeout  out  1  one-cycle pulse on watchdog abort; constant 0 when watchdog compiled out

## Operation
- Framing: Sop pulse, control word (Vld), data words (Vld, gaps allowed), Eop pulse. Sop, Vld and Eop of one port are never high in the same cycle.
- FSM states: IDLE, WAIT_SOP, XFER.
- IDLE: if any iReq, grant the first requesting port at or after rr_ptr (wrapping at NUM_PORTS-1 -> 0); go to WAIT_SOP. If none, stay.
- WAIT_SOP: on granted iWrSop, forward Sop and go to XFER. If granted iReq drops before Sop, withdraw grant, go to IDLE; rr_ptr unchanged.
- XFER: forward granted Vld/Data; on granted iWrEop, forward Eop, release, rr_ptr = granted+1 (mod NUM_PORTS), go to IDLE.
- Strobes from non-granted ports are ignored and never reach the output. A repeated Sop in XFER is dropped. Vld in WAIT_SOP is dropped.
- rr_ptr resets to 0. After a completed packet, the port just served has lowest priority.

## Timing
- Reset values: oGnt=0, oWrSop=0, oWrEop=0, oWrVld=0, oWrData=0, oBusy=0, oTimeout=0, state IDLE, rr_ptr=0, watchdog=0. Reset mid-packet aborts with no Eop emitted.
- Arbitration: iReq sampled high at edge t -> oGnt and oBusy high after edge t+1.
- Datapath latency: each accepted input strobe appears on the output exactly 1 cycle later, with data.
- Release: granted Eop sampled at edge t -> oWrEop high and oGnt/oBusy low after edge t+1; earliest next grant after edge t+2. This gives one idle cycle between packets.
- Simultaneous requests are resolved only in IDLE. Requests arriving during a packet wait, with no starvation: each port waits at most NUM_PORTS-1 packets.

## Configuration
- ARB_TIMEOUT_EN defined: the watchdog counts cycles while oBusy is high and clears on release.
  - If the count reaches TIMEOUT_CYC-1 without Eop, the block drives oWrEop=1 (if in XFER) and oTimeout=1 for one cycle, releases the grant, and advances rr_ptr past the port.
  - A late Eop from the aborted port is ignored.
- ARB_TIMEOUT_EN undefined: no counter; a grant is held indefinitely until Eop or request withdrawal; oTimeout is tied to 0.

## Test plan
- Single port: port 2 sends a 64-byte packet (Sop, ctrl 0x0000_3F00, 16 data words, Eop) -> output is an identical sequence, each strobe 1 cycle late; oGnt=4'b0100 throughout; rr_ptr becomes 3.
- Contention: iReq=4'b1111 in the same cycle, each port sends one 64-byte packet -> grant order 0,1,2,3, one idle cycle between each Eop and the next grant, no interleaved words.
- Isolation: port 1 toggles Sop/Vld/Eop while port 0 is granted -> the output carries only port 0 words; port 1 is served next.
- Withdrawal: port 3 is granted and drops iReq before Sop -> oGnt=0 one cycle later, no output strobes; a pending port 0 is granted next.
- Watchdog (ARB_TIMEOUT_EN, TIMEOUT_CYC=32): port 1 sends Sop, ctrl and 2 words, then stalls -> oWrEop and oTimeout pulse 32 cycles after the grant; port 2 is granted next; port 1's later Eop does not appear on the output.
- Reset mid-XFER: iRst high for 1 cycle -> all outputs 0 next cycle; a new request is granted starting from port 0.
